inst_realign: RTL and testbench
===============================

INST_REALIGN -- requirements
Module: inst_realign

Interface
REQ-001 SHALL have ports: clk_i  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have ports: rst_n_i  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: fetch_valid_i  in  1  fetch word present; fetch_data_i  in  32  word-aligned imem word, low halfword = lower address; fetch_pc_i  in  32  word address (bits[1:0]=0).
REQ-004 SHALL have ports: fetch_ready_o  out  1  word accepted when fetch_valid_i && fetch_ready_o at a clock edge.
REQ-005 SHALL have ports: flush_i  in  1  redirect; flush_pc_i  in  32  halfword-aligned target (bit0=0).
REQ-006 SHALL have ports: inst_valid_o  out  1; inst_o  out  32  instruction to decode/immediate generation; inst_pc_o  out  32; inst_compressed_o  out  1; inst_ready_i  in  1  consumer accepts when inst_valid_o && inst_ready_i.

Function
REQ-007 SHALL hold a halfword queue of 4 entries with count 0..4, plus a head PC register.
REQ-008 SHALL drive fetch_ready_o = (count <= 2) && !flush_i, combinationally.
REQ-009 SHALL, on accepting a word, enqueue low then high halfword; if a post-flush drop flag is set, SHALL enqueue only the high halfword and clear the flag.
REQ-010 SHALL treat the head halfword as compressed when bits[1:0] != 2'b11 (needs 1 entry), otherwise as 32-bit (needs 2 entries, head = bits[15:0]).
REQ-011 SHALL use a registered output stage: when the stage is empty or being consumed and a complete instruction is queued, it SHALL load inst_o/inst_pc_o/inst_compressed_o and set inst_valid_o on the next edge; a word accepted at edge N SHALL yield inst_valid_o after edge N+1 at the earliest.
REQ-012 SHALL hold inst_o, inst_pc_o, inst_compressed_o stable while inst_valid_o && !inst_ready_i.
REQ-013 SHALL advance the head PC by 2 (compressed) or 4 (32-bit), modulo 2^32.
REQ-014 SHALL support a 32-bit instruction straddling two fetch words (low half in word N high entry, high half in word N+1 low entry).
REQ-015 SHALL allow enqueue and dequeue in the same cycle; new count = count + enq - deq, never exceeding 4.
REQ-016 SHALL, when flush_i=1 at an edge: clear the queue and output stage (inst_valid_o=0 next cycle), discard any word presented that cycle, load head PC = flush_pc_i, and set drop flag = flush_pc_i[1].
REQ-017 SHALL give flush_i priority over every simultaneous enqueue, dequeue or output load.

Reset
REQ-018 SHALL, while rst_n_i=0, clear inst_valid_o, inst_o, inst_pc_o, inst_compressed_o, count, drop flag and head PC to 0, independent of clk_i.
REQ-019 SHALL present fetch_ready_o=1 during and after reset (count=0, flush_i low).
REQ-020 SHALL, on reset assertion mid-operation, discard all queued halfwords and any held output.

Configuration
REQ-021 SHALL, with RVC_EXPAND_EN defined, expand compressed instructions to 32-bit RV32I equivalents for C.ADDI, C.LI, C.MV, C.ADD, C.SUB, C.AND, C.OR, C.XOR, C.ANDI, C.SLLI, C.SRLI, C.SRAI, C.LW, C.SW, C.J, C.JAL, C.JR, C.JALR, C.BEQZ, C.BNEZ; any other compressed encoding SHALL yield inst_o = 32'h0000_0000.
REQ-022 SHALL, without RVC_EXPAND_EN, output inst_o = {16'h0000, halfword} for compressed instructions; inst_compressed_o, PC stepping and queueing SHALL be identical in both builds.

Verification
REQ-023 SHALL cover: reset, word 0x00000013 @pc 0x0 -> inst_o=0x00000013, inst_pc_o=0x0, inst_compressed_o=0, valid one cycle after acceptance.
REQ-024 SHALL cover: word 0x45014081 @0x0 (RVC_EXPAND_EN) -> 0x00000093 @0x0, then 0x00000513 @0x2, both inst_compressed_o=1.
REQ-025 SHALL cover: words 0x00134081 @0x0, 0x45010000 @0x4 -> 0x00000093 @0x0, 0x00000013 @0x2 (straddled), 0x00000513 @0x6.
REQ-026 SHALL cover: flush_i with flush_pc_i=0x102, then word 0x45014081 @0x100 -> only 0x00000513 @0x102; word presented in the flush cycle never emitted.
REQ-027 SHALL cover: inst_ready_i=0 for 3 cycles with words streaming -> outputs held stable, fetch_ready_o drops to 0 once count>2, no instruction lost or duplicated after inst_ready_i returns to 1.

Source files
------------

// File: rtl/inst_realign.sv
// Instruction realigner: splits fetch words into halfwords and emits whole 16/32-bit instructions.
// Define RVC_EXPAND_EN to expand supported compressed instructions to their RV32I equivalents.
module inst_realign (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        fetch_valid_i,
    input  logic [31:0] fetch_data_i,
    input  logic [31:0] fetch_pc_i,
    output logic        fetch_ready_o,
    input  logic        flush_i,
    input  logic [31:0] flush_pc_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    output logic        inst_compressed_o,
    input  logic        inst_ready_i
);

    localparam int DEPTH = 4;

    logic [DEPTH-1:0][15:0] r_q;
    logic [2:0]             r_count;
    logic [31:0]            r_head_pc;
    logic                   r_drop;
    logic                   r_inst_valid;
    logic [31:0]            r_inst;
    logic [31:0]            r_inst_pc;
    logic                   r_inst_comp;

    logic                   w_head_comp;
    logic                   w_avail;
    logic                   w_load;
    logic                   w_accept;
    logic [2:0]             w_deq;
    logic [2:0]             w_enq;
    logic [1:0]             w_base;
    logic [2:0]             w_count_next;
    logic [DEPTH-1:0][15:0] w_q_shift;
    logic [DEPTH-1:0][15:0] w_q_next;
    logic [31:0]            w_inst_next;
    logic                   w_unused_fetch_pc;

    // The head PC is tracked internally, so the fetch word address carries no extra information.
    assign w_unused_fetch_pc = ^fetch_pc_i;

`ifdef RVC_EXPAND_EN
    function automatic logic [31:0] rvc_expand(input logic [15:0] c);
        logic [4:0]  rd;
        logic [4:0]  rs2;
        logic [4:0]  rdp;
        logic [4:0]  rs2p;
        logic [11:0] imm6;
        logic [11:0] j_off;
        logic [8:0]  b_off;
        logic [31:0] r;
        rd    = c[11:7];
        rs2   = c[6:2];
        rdp   = {2'b01, c[9:7]};
        rs2p  = {2'b01, c[4:2]};
        imm6  = {{7{c[12]}}, c[6:2]};
        j_off = {c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], 1'b0};
        b_off = {c[12], c[6:5], c[2], c[11:10], c[4:3], 1'b0};
        r     = 32'h0000_0000;
        case ({c[1:0], c[15:13]})
            5'b00_010: r = {5'b0, c[5], c[12:10], c[6], 2'b00, rdp, 3'b010, rs2p, 7'b0000011};
            5'b00_110: r = {5'b0, c[5], c[12], rs2p, rdp, 3'b010, c[11:10], c[6], 2'b00, 7'b0100011};
            5'b01_000: r = {imm6, rd, 3'b000, rd, 7'b0010011};
            5'b01_001: r = {j_off[11], j_off[10:1], j_off[11], {8{j_off[11]}}, 5'd1, 7'b1101111};
            5'b01_010: r = {imm6, 5'd0, 3'b000, rd, 7'b0010011};
            5'b01_100: begin
                case (c[11:10])
                    2'b00: if (!c[12]) r = {7'b0000000, rs2, rdp, 3'b101, rdp, 7'b0010011};
                    2'b01: if (!c[12]) r = {7'b0100000, rs2, rdp, 3'b101, rdp, 7'b0010011};
                    2'b10: r = {imm6, rdp, 3'b111, rdp, 7'b0010011};
                    default: begin
                        // c[12]=1 selects the RV64-only word ops, which stay illegal here.
                        if (!c[12]) begin
                            case (c[6:5])
                                2'b00:   r = {7'b0100000, rs2p, rdp, 3'b000, rdp, 7'b0110011};
                                2'b01:   r = {7'b0000000, rs2p, rdp, 3'b100, rdp, 7'b0110011};
                                2'b10:   r = {7'b0000000, rs2p, rdp, 3'b110, rdp, 7'b0110011};
                                default: r = {7'b0000000, rs2p, rdp, 3'b111, rdp, 7'b0110011};
                            endcase
                        end
                    end
                endcase
            end
            5'b01_101: r = {j_off[11], j_off[10:1], j_off[11], {8{j_off[11]}}, 5'd0, 7'b1101111};
            5'b01_110: r = {b_off[8], {2{b_off[8]}}, b_off[8:5], 5'd0, rdp, 3'b000, b_off[4:1], b_off[8], 7'b1100011};
            5'b01_111: r = {b_off[8], {2{b_off[8]}}, b_off[8:5], 5'd0, rdp, 3'b001, b_off[4:1], b_off[8], 7'b1100011};
            5'b10_000: if (!c[12]) r = {7'b0000000, rs2, rd, 3'b001, rd, 7'b0010011};
            5'b10_100: begin
                if (!c[12]) begin
                    if (rs2 == 5'd0) begin
                        if (rd != 5'd0) r = {12'h000, rd, 3'b000, 5'd0, 7'b1100111};
                    end else begin
                        r = {7'b0000000, rs2, 5'd0, 3'b000, rd, 7'b0110011};
                    end
                end else begin
                    if (rs2 == 5'd0) begin
                        if (rd != 5'd0) r = {12'h000, rd, 3'b000, 5'd1, 7'b1100111};
                    end else begin
                        r = {7'b0000000, rs2, rd, 3'b000, rd, 7'b0110011};
                    end
                end
            end
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction
`endif

    assign w_head_comp   = (r_q[0][1:0] != 2'b11);
    assign w_avail       = (r_count >= 3'd2) || ((r_count == 3'd1) && w_head_comp);
    assign w_load        = w_avail && (!r_inst_valid || inst_ready_i);
    assign w_deq         = w_load ? (w_head_comp ? 3'd1 : 3'd2) : 3'd0;
    assign fetch_ready_o = (r_count <= 3'd2) && !flush_i;
    assign w_accept      = fetch_valid_i && fetch_ready_o;
    assign w_enq         = w_accept ? (r_drop ? 3'd1 : 3'd2) : 3'd0;
    assign w_base        = 2'(r_count - w_deq);
    assign w_count_next  = r_count - w_deq + w_enq;

    // NOTE: every signal written here gets its default first, so no path can infer a latch.
    always_comb begin
        w_q_shift = r_q >> {w_deq, 4'b0000};
        w_q_next  = w_q_shift;
        if (w_accept) begin
            if (r_drop) begin
                w_q_next[w_base] = fetch_data_i[31:16];
            end else begin
                w_q_next[w_base]         = fetch_data_i[15:0];
                w_q_next[w_base + 2'd1]  = fetch_data_i[31:16];
            end
        end
    end

`ifdef RVC_EXPAND_EN
    assign w_inst_next = w_head_comp ? rvc_expand(r_q[0]) : {r_q[1], r_q[0]};
`else
    assign w_inst_next = w_head_comp ? {16'h0000, r_q[0]} : {r_q[1], r_q[0]};
`endif

    // NOTE: halfword storage is deliberately not reset; r_count alone decides which entries are live.
    always_ff @(posedge clk_i) begin
        r_q <= w_q_next;
    end

    // NOTE: clocked state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_count   <= 3'd0;
            r_head_pc <= 32'h0000_0000;
            r_drop    <= 1'b0;
        end else if (flush_i) begin
            r_count   <= 3'd0;
            r_head_pc <= flush_pc_i;
            r_drop    <= flush_pc_i[1];
        end else begin
            r_count <= w_count_next;
            if (w_load) begin
                r_head_pc <= r_head_pc + (w_head_comp ? 32'd2 : 32'd4);
            end
            if (w_accept && r_drop) begin
                r_drop <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_inst_valid <= 1'b0;
            r_inst       <= 32'h0000_0000;
            r_inst_pc    <= 32'h0000_0000;
            r_inst_comp  <= 1'b0;
        end else if (flush_i) begin
            r_inst_valid <= 1'b0;
        end else if (w_load) begin
            r_inst_valid <= 1'b1;
            r_inst       <= w_inst_next;
            r_inst_pc    <= r_head_pc;
            r_inst_comp  <= w_head_comp;
        end else if (inst_ready_i) begin
            r_inst_valid <= 1'b0;
        end
    end

    assign inst_valid_o      = r_inst_valid;
    assign inst_o            = r_inst;
    assign inst_pc_o         = r_inst_pc;
    assign inst_compressed_o = r_inst_comp;

endmodule

// File: tb/tb_inst_realign.sv
// Self-checking bench for inst_realign: directed cases plus randomized traffic against a
// transaction-level model (halfword stream -> instruction list). Honours RVC_EXPAND_EN.
module tb_inst_realign;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        fetch_valid_i;
    logic [31:0] fetch_data_i;
    logic [31:0] fetch_pc_i;
    logic        fetch_ready_o;
    logic        flush_i;
    logic [31:0] flush_pc_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_compressed_o;
    logic        inst_ready_i;

    always #5 clk_i = ~clk_i;

    inst_realign dut (
        .clk_i             (clk_i),
        .rst_n_i           (rst_n_i),
        .fetch_valid_i     (fetch_valid_i),
        .fetch_data_i      (fetch_data_i),
        .fetch_pc_i        (fetch_pc_i),
        .fetch_ready_o     (fetch_ready_o),
        .flush_i           (flush_i),
        .flush_pc_i        (flush_pc_i),
        .inst_valid_o      (inst_valid_o),
        .inst_o            (inst_o),
        .inst_pc_o         (inst_pc_o),
        .inst_compressed_o (inst_compressed_o),
        .inst_ready_i      (inst_ready_i)
    );

`ifdef RVC_EXPAND_EN
    localparam logic [31:0] E_4081 = 32'h0000_0093;
    localparam logic [31:0] E_4501 = 32'h0000_0513;
`else
    localparam logic [31:0] E_4081 = 32'h0000_4081;
    localparam logic [31:0] E_4501 = 32'h0000_4501;
`endif

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        comp;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] hq[$];
    logic [31:0] m_pc;
    logic        m_drop;
    logic        hold;
    logic [31:0] h_inst;
    logic [31:0] h_pc;
    logic        h_comp;
    bit          f_fire;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          k;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Generic RV32 encoders used by the expansion model.
    function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input int op);
        logic [11:0] i12;
        i12 = imm[11:0];
        return {i12, rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
    endfunction

    function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd, input int op);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
    endfunction

    function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1, input int f3, input int op);
        logic [11:0] s;
        s = imm[11:0];
        return {s[11:5], rs2[4:0], rs1[4:0], f3[2:0], s[4:0], op[6:0]};
    endfunction

    function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
        logic [12:0] b;
        b = imm[12:0];
        return {b[12], b[10:5], rs2[4:0], rs1[4:0], f3[2:0], b[4:1], b[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_j(input int imm, input int rd);
        logic [20:0] j;
        j = imm[20:0];
        return {j[20], j[10:1], j[11], j[19:12], rd[4:0], 7'h6f};
    endfunction

    function automatic logic [31:0] m_expand(input logic [15:0] c);
`ifdef RVC_EXPAND_EN
        int rd, rs2, rdp, rs2p, simm, uoff, joff, boff;
        rd   = int'(c[11:7]);
        rs2  = int'(c[6:2]);
        rdp  = 8 + int'(c[9:7]);
        rs2p = 8 + int'(c[4:2]);
        simm = int'($signed({c[12], c[6:2]}));
        uoff = 64 * int'(c[5]) + 8 * int'(c[12:10]) + 4 * int'(c[6]);
        joff = 2 * int'(c[5:3]) + 16 * int'(c[11]) + 32 * int'(c[2]) + 64 * int'(c[7])
             + 128 * int'(c[6]) + 256 * int'(c[10:9]) + 1024 * int'(c[8]) - 2048 * int'(c[12]);
        boff = 2 * int'(c[4:3]) + 8 * int'(c[11:10]) + 32 * int'(c[2]) + 64 * int'(c[6:5])
             - 256 * int'(c[12]);
        if (c[1:0] == 2'b00) begin
            if (c[15:13] == 3'd2) return enc_i(uoff, rdp, 2, rs2p, 'h03);
            if (c[15:13] == 3'd6) return enc_s(uoff, rs2p, rdp, 2, 'h23);
        end else if (c[1:0] == 2'b01) begin
            case (c[15:13])
                3'd0: return enc_i(simm, rd, 0, rd, 'h13);
                3'd1: return enc_j(joff, 1);
                3'd2: return enc_i(simm, 0, 0, rd, 'h13);
                3'd4: begin
                    if (c[11:10] == 2'd2) return enc_i(simm, rdp, 7, rdp, 'h13);
                    if (c[12] == 1'b0) begin
                        if (c[11:10] == 2'd0) return enc_i(rs2, rdp, 5, rdp, 'h13);
                        if (c[11:10] == 2'd1) return enc_i('h400 + rs2, rdp, 5, rdp, 'h13);
                        case (c[6:5])
                            2'd0: return enc_r('h20, rs2p, rdp, 0, rdp, 'h33);
                            2'd1: return enc_r(0, rs2p, rdp, 4, rdp, 'h33);
                            2'd2: return enc_r(0, rs2p, rdp, 6, rdp, 'h33);
                            default: return enc_r(0, rs2p, rdp, 7, rdp, 'h33);
                        endcase
                    end
                end
                3'd5: return enc_j(joff, 0);
                3'd6: return enc_b(boff, 0, rdp, 0);
                3'd7: return enc_b(boff, 0, rdp, 1);
                default: return 32'h0;
            endcase
        end else if (c[1:0] == 2'b10) begin
            if (c[15:13] == 3'd0 && c[12] == 1'b0) return enc_i(rs2, rd, 1, rd, 'h13);
            if (c[15:13] == 3'd4) begin
                if (rs2 != 0) return (c[12] ? enc_r(0, rs2, rd, 0, rd, 'h33) : enc_r(0, rs2, 0, 0, rd, 'h33));
                if (rd != 0)  return enc_i(0, rd, 0, c[12] ? 1 : 0, 'h67);
            end
        end
        return 32'h0;
`else
        return {16'h0000, c};
`endif
    endfunction

    function automatic logic [31:0] word_k(input int n);
        return 32'h0000_0093 | (n << 20);
    endfunction

    task automatic model_accept(input logic [31:0] w);
        exp_t e;
        if (m_drop) begin
            hq.push_back(w[31:16]);
            m_drop = 1'b0;
        end else begin
            hq.push_back(w[15:0]);
            hq.push_back(w[31:16]);
        end
        while (hq.size() > 0) begin
            if (hq[0][1:0] != 2'b11) begin
                e.inst = m_expand(hq[0]); e.pc = m_pc; e.comp = 1'b1;
                exp_q.push_back(e);
                m_pc += 32'd2;
                void'(hq.pop_front());
            end else if (hq.size() >= 2) begin
                e.inst = {hq[1], hq[0]}; e.pc = m_pc; e.comp = 1'b0;
                exp_q.push_back(e);
                m_pc += 32'd4;
                void'(hq.pop_front());
                void'(hq.pop_front());
            end else begin
                break;
            end
        end
    endtask

    // Evaluates handshakes just before the edge, then lets the edge happen.
    task automatic cycle();
        exp_t e;
        f_fire = 1'b0;
        @(negedge clk_i);
        if (!rst_n_i) begin
            hq.delete(); exp_q.delete();
            m_pc = 32'h0; m_drop = 1'b0; hold = 1'b0;
        end else begin
            if (hold) begin
                check("hold_valid", 32'(inst_valid_o), 32'd1);
                check("hold_inst", inst_o, h_inst);
                check("hold_pc", inst_pc_o, h_pc);
                check("hold_comp", 32'(inst_compressed_o), 32'(h_comp));
            end
            if (flush_i) begin
                check("flush_fetch_ready", 32'(fetch_ready_o), 32'd0);
                hq.delete(); exp_q.delete();
                m_pc = flush_pc_i; m_drop = flush_pc_i[1]; hold = 1'b0;
            end else begin
                if (inst_valid_o && inst_ready_i) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_inst", 32'(inst_valid_o), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("sb_inst", inst_o, e.inst);
                        check("sb_pc", inst_pc_o, e.pc);
                        check("sb_comp", 32'(inst_compressed_o), 32'(e.comp));
                    end
                end
                if (fetch_valid_i && fetch_ready_o) begin
                    f_fire = 1'b1;
                    model_accept(fetch_data_i);
                end
                hold   = inst_valid_o && !inst_ready_i;
                h_inst = inst_o; h_pc = inst_pc_o; h_comp = inst_compressed_o;
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_flush(input logic [31:0] pc);
        flush_i = 1'b1; flush_pc_i = pc;
        cycle();
        flush_i = 1'b0;
    endtask

    task automatic stream_cycle();
        cycle();
        if (f_fire) begin
            k++;
            fetch_data_i = word_k(k);
            fetch_pc_i   = fetch_pc_i + 32'd4;
            if (k >= 6) fetch_valid_i = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rnd;
        rst_n_i = 1'b0; fetch_valid_i = 1'b0; fetch_data_i = '0; fetch_pc_i = '0;
        flush_i = 1'b0; flush_pc_i = '0; inst_ready_i = 1'b1;
        hold = 1'b0; m_pc = '0; m_drop = 1'b0; k = 0;
        #1;
        check("rst_valid", 32'(inst_valid_o), 32'd0);
        check("rst_inst", inst_o, 32'd0);
        check("rst_pc", inst_pc_o, 32'd0);
        check("rst_comp", 32'(inst_compressed_o), 32'd0);
        check("rst_fetch_ready", 32'(fetch_ready_o), 32'd1);
        cycle(); cycle();
        check("rst_fetch_ready_hold", 32'(fetch_ready_o), 32'd1);
        rst_n_i = 1'b1;

        // Single 32-bit word: one-cycle output latency.
        fetch_valid_i = 1'b1; fetch_data_i = 32'h0000_0013; fetch_pc_i = 32'h0;
        cycle();
        fetch_valid_i = 1'b0;
        check("lat_not_yet", 32'(inst_valid_o), 32'd0);
        cycle();
        check("w32_valid", 32'(inst_valid_o), 32'd1);
        check("w32_inst", inst_o, 32'h0000_0013);
        check("w32_pc", inst_pc_o, 32'h0);
        check("w32_comp", 32'(inst_compressed_o), 32'd0);
        cycle();
        check("w32_done", 32'(inst_valid_o), 32'd0);

        // Two compressed instructions in one word.
        do_flush(32'h0);
        fetch_valid_i = 1'b1; fetch_data_i = 32'h4501_4081; fetch_pc_i = 32'h0;
        cycle();
        fetch_valid_i = 1'b0;
        cycle();
        check("c0_inst", inst_o, E_4081);
        check("c0_pc", inst_pc_o, 32'h0);
        check("c0_comp", 32'(inst_compressed_o), 32'd1);
        cycle();
        check("c1_inst", inst_o, E_4501);
        check("c1_pc", inst_pc_o, 32'h2);
        check("c1_comp", 32'(inst_compressed_o), 32'd1);
        cycle();
        check("c_done", 32'(inst_valid_o), 32'd0);

        // 32-bit instruction straddling two fetch words.
        do_flush(32'h0);
        fetch_valid_i = 1'b1; fetch_data_i = 32'h0013_4081; fetch_pc_i = 32'h0;
        cycle();
        fetch_data_i = 32'h4501_0000; fetch_pc_i = 32'h4;
        cycle();
        fetch_valid_i = 1'b0;
        check("st0_inst", inst_o, E_4081);
        check("st0_pc", inst_pc_o, 32'h0);
        cycle();
        check("st1_inst", inst_o, 32'h0000_0013);
        check("st1_pc", inst_pc_o, 32'h2);
        check("st1_comp", 32'(inst_compressed_o), 32'd0);
        cycle();
        check("st2_inst", inst_o, E_4501);
        check("st2_pc", inst_pc_o, 32'h6);
        cycle();
        check("st_done", 32'(inst_valid_o), 32'd0);

        // Flush to an odd halfword; the word offered during the flush is discarded.
        fetch_valid_i = 1'b1; fetch_data_i = 32'h4081_4081; fetch_pc_i = 32'h500;
        do_flush(32'h102);
        check("fl_valid0", 32'(inst_valid_o), 32'd0);
        fetch_data_i = 32'h4501_4081; fetch_pc_i = 32'h100;
        cycle();
        fetch_valid_i = 1'b0;
        check("fl_valid1", 32'(inst_valid_o), 32'd0);
        cycle();
        check("fl_valid2", 32'(inst_valid_o), 32'd1);
        check("fl_inst", inst_o, E_4501);
        check("fl_pc", inst_pc_o, 32'h102);
        check("fl_comp", 32'(inst_compressed_o), 32'd1);
        cycle();
        check("fl_done", 32'(inst_valid_o), 32'd0);

        // Consumer stall while words stream in: backpressure and no loss/duplication.
        inst_ready_i = 1'b0;
        do_flush(32'h200);
        k = 0; fetch_valid_i = 1'b1; fetch_data_i = word_k(0); fetch_pc_i = 32'h200;
        stream_cycle();
        check("bp_fr1", 32'(fetch_ready_o), 32'd1);
        stream_cycle();
        check("bp_fr2", 32'(fetch_ready_o), 32'd1);
        check("bp_valid", 32'(inst_valid_o), 32'd1);
        stream_cycle();
        check("bp_fr3", 32'(fetch_ready_o), 32'd0);
        check("bp_inst3", inst_o, word_k(0));
        stream_cycle();
        check("bp_fr4", 32'(fetch_ready_o), 32'd0);
        stream_cycle();
        check("bp_inst5", inst_o, word_k(0));
        inst_ready_i = 1'b1;
        for (int i = 0; i < 40 && (k < 6 || exp_q.size() > 0 || inst_valid_o); i++) stream_cycle();
        check("bp_words_taken", 32'(k), 32'd6);
        check("bp_all_emitted", 32'(exp_q.size()), 32'd0);

        // PC wrap across 2^32.
        do_flush(32'hFFFF_FFFC);
        fetch_valid_i = 1'b1; fetch_data_i = 32'h4081_4081; fetch_pc_i = 32'hFFFF_FFFC;
        cycle();
        fetch_data_i = 32'h0000_0013; fetch_pc_i = 32'h0;
        cycle();
        fetch_valid_i = 1'b0;
        for (int i = 0; i < 6; i++) cycle();
        check("wrap_all_emitted", 32'(exp_q.size()), 32'd0);

        // Randomized traffic with occasional flushes and one asynchronous reset.
        fetch_pc_i = m_pc & 32'hFFFF_FFFC;
        for (int it = 0; it < 3000; it++) begin
            fetch_valid_i = ($urandom_range(0, 3) != 0);
            fetch_data_i  = $urandom();
            inst_ready_i  = ($urandom_range(0, 3) != 0);
            flush_i       = ($urandom_range(0, 39) == 0);
            rnd           = $urandom();
            flush_pc_i    = {rnd[31:1], 1'b0};
            if (it == 1500) begin
                flush_i = 1'b0; fetch_valid_i = 1'b0;
                #2 rst_n_i = 1'b0;
                #1;
                check("arst_valid", 32'(inst_valid_o), 32'd0);
                check("arst_inst", inst_o, 32'd0);
                check("arst_pc", inst_pc_o, 32'd0);
                check("arst_comp", 32'(inst_compressed_o), 32'd0);
                check("arst_fetch_ready", 32'(fetch_ready_o), 32'd1);
                cycle();
                rst_n_i = 1'b1; fetch_pc_i = 32'h0;
                continue;
            end
            cycle();
            if (flush_i) fetch_pc_i = flush_pc_i & 32'hFFFF_FFFC;
            else if (f_fire) fetch_pc_i = fetch_pc_i + 32'd4;
        end

        flush_i = 1'b0; fetch_valid_i = 1'b0; inst_ready_i = 1'b1;
        for (int i = 0; i < 20 && (exp_q.size() > 0 || inst_valid_o); i++) cycle();
        check("final_all_emitted", 32'(exp_q.size()), 32'd0);
        check("final_idle", 32'(inst_valid_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
